// File: rtl/pipe_ctrl.sv
// pipe_ctrl -- pipeline sequencing controller for the 5-stage MIPS32 core.
//
// Merges the ID/EX/MEM stall requests into a per-stage hold vector, turns a
// MEM exception into a one-cycle flush with a redirect PC, and tracks stall
// activity (sticky timeout on a long run of consecutive stalls plus a
// free-running count of stalled cycles).
//
// Ports:
//   clk            core clock, rising edge
//   rst            asynchronous active-high reset
//   stallreq_id    ID stall request (load-use hazard)
//   stallreq_ex    EX stall request (multi-cycle op busy)
//   stallreq_mem   MEM stall request (data memory wait)
//   excp_valid     exception reported by MEM this cycle
//   excp_pc        handler address accompanying excp_valid
//   timeout_clr    clears stall_timeout
//   stall[5:0]     hold vector: [0] PC, [1] IF/ID, [2] ID/EX, [3] EX/MEM,
//                  [4] MEM/WB, [5] WB (reserved, always 0)
//   flush          clear all pipeline registers and load new_pc
//   new_pc[31:0]   redirect PC, valid while flush is high
//   stall_timeout  sticky: STALL_MAX consecutive stall cycles seen
//   stall_cycles   total cycles with stall nonzero (wraps)
module pipe_ctrl #(
  parameter int STALL_MAX = 255,
  parameter int CNT_W     = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic        excp_valid,
  input  logic [31:0] excp_pc,
  input  logic        timeout_clr,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        stall_timeout,
  output logic [31:0] stall_cycles
);

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] RUN_MAX     = CNT_W'(STALL_MAX);
  localparam logic [CNT_W-1:0] RUN_MAX_M1  = CNT_W'(STALL_MAX - 1);

  state_t             state_q, state_d;
  logic [31:0]        new_pc_q, new_pc_d;
  logic               timeout_q, timeout_d;
  logic [31:0]        cycles_q, cycles_d;
  logic [CNT_W-1:0]   run_cnt_q, run_cnt_d;
  logic               stalling;
  logic               timeout_set;

  // Next-state and combinational stall vector.
  always_comb begin
    state_d     = state_q;
    new_pc_d    = new_pc_q;
    stall       = 6'b000000;

    case (state_q)
      RUN: begin
        if (excp_valid) begin
          // Exception beats any stall request; the flush next cycle
          // squashes whatever the stalled stages were holding.
          state_d  = FLUSH;
          new_pc_d = excp_pc;
        end else if (stallreq_mem) begin
          stall = 6'b011111;
        end else if (stallreq_ex) begin
          stall = 6'b001111;
        end else if (stallreq_id) begin
          stall = 6'b000111;
        end
      end
      FLUSH: begin
        // Everything is ignored here, including a new exception: the
        // flush cancels the instruction that would have raised it.
        state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  assign stalling = (stall != 6'b000000);

  // Stall bookkeeping.
  always_comb begin
    run_cnt_d   = run_cnt_q;
    cycles_d    = cycles_q;
    timeout_set = 1'b0;

    if (stalling) begin
      cycles_d = cycles_q + 32'd1;
      if (run_cnt_q != RUN_MAX) begin
        run_cnt_d = run_cnt_q + 1'b1;
      end
      // Fire only on the transition into saturation, so a long stall that
      // stays saturated cannot re-set the flag after software cleared it.
      timeout_set = (run_cnt_q == RUN_MAX_M1);
    end else begin
      run_cnt_d = '0;
    end

    // Set has priority over a same-cycle clear.
    if (timeout_set) begin
      timeout_d = 1'b1;
    end else if (timeout_clr) begin
      timeout_d = 1'b0;
    end else begin
      timeout_d = timeout_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RUN;
      new_pc_q  <= 32'h00000000;
      timeout_q <= 1'b0;
      cycles_q  <= 32'h00000000;
      run_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      new_pc_q  <= new_pc_d;
      timeout_q <= timeout_d;
      cycles_q  <= cycles_d;
      run_cnt_q <= run_cnt_d;
    end
  end

  assign flush         = (state_q == FLUSH);
  assign new_pc        = new_pc_q;
  assign stall_timeout = timeout_q;
  assign stall_cycles  = cycles_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl (STALL_MAX = 4).
module tb_pipe_ctrl;

  localparam int SMAX = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stallreq_id = 1'b0;
  logic        stallreq_ex = 1'b0;
  logic        stallreq_mem = 1'b0;
  logic        excp_valid = 1'b0;
  logic [31:0] excp_pc = 32'h0;
  logic        timeout_clr = 1'b0;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        stall_timeout;
  logic [31:0] stall_cycles;

  int checks = 0;
  int errors = 0;

  pipe_ctrl #(.STALL_MAX(SMAX), .CNT_W(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .stallreq_id   (stallreq_id),
    .stallreq_ex   (stallreq_ex),
    .stallreq_mem  (stallreq_mem),
    .excp_valid    (excp_valid),
    .excp_pc       (excp_pc),
    .timeout_clr   (timeout_clr),
    .stall         (stall),
    .flush         (flush),
    .new_pc        (new_pc),
    .stall_timeout (stall_timeout),
    .stall_cycles  (stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Flush pending flag, last redirect PC, unbounded consecutive-stall run
  // length, sticky timeout and the wrapping stall count.
  logic        m_flush   = 1'b0;
  logic [31:0] m_pc      = 32'h0;
  int          m_consec  = 0;
  logic        m_timeout = 1'b0;
  logic [31:0] m_cycles  = 32'h0;

  function automatic logic [5:0] exp_stall(input logic in_flush, input logic ev,
                                           input logic mem, input logic ex, input logic id);
    if (in_flush || ev) return 6'd0;
    if (mem) return 6'b011111;
    if (ex)  return 6'b001111;
    if (id)  return 6'b000111;
    return 6'd0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_flush = 1'b0; m_pc = 32'h0; m_consec = 0; m_timeout = 1'b0; m_cycles = 32'h0;
    end else begin
      logic set_ev;
      set_ev = 1'b0;
      if (exp_stall(m_flush, excp_valid, stallreq_mem, stallreq_ex, stallreq_id) != 6'd0) begin
        m_consec++;
        m_cycles = m_cycles + 32'd1;
        if (m_consec == SMAX) set_ev = 1'b1;
      end else begin
        m_consec = 0;
      end
      if (set_ev) m_timeout = 1'b1;
      else if (timeout_clr) m_timeout = 1'b0;
      if (!m_flush && excp_valid) begin
        m_flush = 1'b1;
        m_pc    = excp_pc;
      end else begin
        m_flush = 1'b0;
      end
    end
  end

  // Compare process: inputs change at the falling edge, outputs settled 2ns later.
  always @(negedge clk) begin
    #2;
    chk("m_stall", {26'd0, stall},
        {26'd0, exp_stall(m_flush, excp_valid, stallreq_mem, stallreq_ex, stallreq_id)});
    chk("m_flush", {31'd0, flush}, {31'd0, m_flush});
    chk("m_new_pc", new_pc, m_pc);
    chk("m_timeout", {31'd0, stall_timeout}, {31'd0, m_timeout});
    chk("m_cycles", stall_cycles, m_cycles);
  end

  // Apply one cycle of inputs at the falling edge.
  task automatic cyc(input logic id, input logic ex, input logic mem,
                     input logic ev, input logic [31:0] pc, input logic clr);
    @(negedge clk);
    stallreq_id = id; stallreq_ex = ex; stallreq_mem = mem;
    excp_valid = ev; excp_pc = pc; timeout_clr = clr;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    // Reset held across the first edge.
    @(negedge clk); #3;
    chk("rst_stall", {26'd0, stall}, 32'd0);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_new_pc", new_pc, 32'h0);
    chk("rst_timeout", {31'd0, stall_timeout}, 32'd0);
    chk("rst_cycles", stall_cycles, 32'd0);

    // Release reset with EX requesting.
    @(negedge clk);
    rst = 1'b0; stallreq_ex = 1'b1;
    #3 chk("first_ex_stall", {26'd0, stall}, 32'h0F);

    // Priority.
    cyc(1, 0, 1, 0, 32'h0, 0); #3 chk("prio_id_mem", {26'd0, stall}, 32'h1F);
    cyc(1, 0, 0, 0, 32'h0, 0); #3 chk("prio_id", {26'd0, stall}, 32'h07);
    cyc(0, 0, 0, 0, 32'h0, 0); #3 chk("prio_none", {26'd0, stall}, 32'h00);
    chk("cycles_after_prio", stall_cycles, 32'd3);

    // Exception while MEM stalls, second exception during FLUSH ignored.
    cyc(0, 0, 1, 1, 32'hBFC00380, 0); #3;
    chk("excp_stall0", {26'd0, stall}, 32'h0);
    chk("excp_noflush_yet", {31'd0, flush}, 32'd0);
    cyc(0, 0, 1, 1, 32'h12345678, 0); #3;
    chk("flush_pulse", {31'd0, flush}, 32'd1);
    chk("flush_pc", new_pc, 32'hBFC00380);
    chk("flush_stall0", {26'd0, stall}, 32'h0);
    cyc(0, 0, 0, 0, 32'h0, 0); #3;
    chk("no_second_flush", {31'd0, flush}, 32'd0);
    chk("pc_held", new_pc, 32'hBFC00380);
    cyc(0, 0, 0, 0, 32'h0, 0); #3 chk("no_second_flush2", {31'd0, flush}, 32'd0);

    // Asynchronous reset with a flush in progress.
    cyc(0, 0, 0, 1, 32'hA0000000, 0);
    @(posedge clk); #2;
    chk("pre_rst_flush", {31'd0, flush}, 32'd1);
    rst = 1'b1; #1;
    chk("async_rst_flush", {31'd0, flush}, 32'd0);
    chk("async_rst_pc", new_pc, 32'h0);
    chk("async_rst_cycles", stall_cycles, 32'd0);
    @(negedge clk);
    rst = 1'b0; excp_valid = 1'b0; excp_pc = 32'h0;
    #3 chk("flush_dropped", {31'd0, flush}, 32'd0);

    // Timeout after 4 consecutive stall cycles.
    repeat (3) cyc(0, 1, 0, 0, 32'h0, 0);
    cyc(0, 1, 0, 0, 32'h0, 0); #3 chk("to_not_yet", {31'd0, stall_timeout}, 32'd0);
    cyc(0, 0, 0, 0, 32'h0, 0); #3;
    chk("to_set", {31'd0, stall_timeout}, 32'd1);
    chk("to_cycles4", stall_cycles, 32'd4);
    cyc(0, 0, 0, 0, 32'h0, 1); #3 chk("to_still_set", {31'd0, stall_timeout}, 32'd1);
    cyc(0, 0, 0, 0, 32'h0, 0); #3 chk("to_cleared", {31'd0, stall_timeout}, 32'd0);

    // 3 stalls, idle, 3 stalls: no timeout.
    repeat (3) cyc(0, 1, 0, 0, 32'h0, 0);
    cyc(0, 0, 0, 0, 32'h0, 0);
    repeat (3) cyc(0, 1, 0, 0, 32'h0, 0);
    cyc(0, 0, 0, 0, 32'h0, 0); #3;
    chk("to_broken_run", {31'd0, stall_timeout}, 32'd0);
    chk("cycles10", stall_cycles, 32'd10);

    // Clear on the 4th stall cycle: set wins.
    repeat (3) cyc(0, 1, 0, 0, 32'h0, 0);
    cyc(0, 1, 0, 0, 32'h0, 1);
    cyc(0, 0, 0, 0, 32'h0, 0); #3 chk("set_beats_clr", {31'd0, stall_timeout}, 32'd1);
    cyc(0, 0, 0, 0, 32'h0, 1);

    // Saturated run: a clear during the 5th stall cycle is not overridden.
    repeat (4) cyc(0, 1, 0, 0, 32'h0, 0);
    cyc(0, 1, 0, 0, 32'h0, 1);
    cyc(0, 1, 0, 0, 32'h0, 0); #3 chk("sat_no_reset", {31'd0, stall_timeout}, 32'd0);
    cyc(0, 0, 0, 0, 32'h0, 0);

    // Stall counter wrap.
    @(negedge clk);
    force dut.cycles_q = 32'hFFFFFFFF;
    m_cycles = 32'hFFFFFFFF;
    #1 release dut.cycles_q;
    stallreq_ex = 1'b1;
    #2 chk("wrap_pre", stall_cycles, 32'hFFFFFFFF);
    cyc(0, 0, 0, 0, 32'h0, 0); #3 chk("wrap_zero", stall_cycles, 32'h0);

    cyc(0, 0, 0, 0, 32'h0, 0);
    @(negedge clk); #4;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
